fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/if_id_reg.sv | 46 ++++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: word width, reset PC, NOP encoding and the
// fetch FSM state encoding used by fetch_unit and if_id_reg.
package fetch_unit_pkg;

  localparam int unsigned WordWidth = 32;

  typedef logic [WordWidth-1:0] word_t;

  localparam word_t ResetPc   = 32'h0000_0000;
  localparam word_t NopInstr  = 32'h0000_0000;
  localparam word_t PcStep    = 32'h0000_0004;
  // Clears the two low bits so every fetch address is word aligned.
  localparam word_t AlignMask = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    StFetch = 2'd0, // request outstanding for pc
    StHold  = 2'd1, // fetched word buffered while decode is stalled
    StDrop  = 2'd2  // stale request outstanding after a redirect
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and flush control.
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   hold_i   keep current contents (highest priority after reset)
//   flush_i  load a NOP bubble instead of instr_i
//   instr_i  instruction word to load
//   pc_i     address of instr_i
//   instr_o  registered instruction (NOP when bubble)
//   pc_o     registered instruction address
//   valid_o  1 = instr_o is real, 0 = bubble
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  hold_i,
  input  logic  flush_i,
  input  word_t instr_i,
  input  word_t pc_i,
  output word_t instr_o,
  output word_t pc_o,
  output logic  valid_o
);

  word_t instr_q;
  word_t pc_q;
  logic  valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q <= NopInstr;
      pc_q    <= ResetPc;
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      instr_q <= flush_i ? NopInstr : instr_i;
      pc_q    <= pc_i;
      valid_q <= !flush_i;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, the fetch FSM and a one-word buffer
// used while decode is stalled, and feeds the IF/ID register.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   Change_PC_en    redirect request from decode; PC_New is the target
//   Stall_IF_ID     freeze PC and IF/ID (overrides a redirect)
//   IMem_Req/Addr   instruction memory read request and address
//   IMem_Ack/Rdata  read data valid and instruction word
//   Instruction     IF/ID instruction, ID_PC its address, ID_Valid real/bubble
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        Change_PC_en,
  input  logic [31:0] PC_New,
  input  logic        Stall_IF_ID,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_Rdata,
  output logic [31:0] Instruction,
  output logic [31:0] ID_PC,
  output logic        ID_Valid
);

  fetch_state_e state_q;
  logic         req_q;
  word_t        pc_q;
  word_t        buf_q;
  word_t        stale_q;

  logic  word_avail;
  logic  id_flush;
  word_t id_instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Memory resets with us, so an in-flight request is simply forgotten.
      state_q <= StFetch;
      req_q   <= 1'b1;
      pc_q    <= ResetPc;
      buf_q   <= NopInstr;
      stale_q <= ResetPc;
    end else if (Stall_IF_ID) begin
      case (state_q)
        StFetch: begin
          if (IMem_Ack) begin
            buf_q   <= IMem_Rdata;
            state_q <= StHold;
            req_q   <= 1'b0;
          end
        end
        StDrop: begin
          // Stale word arrives; pc_q already holds the redirect target.
          if (IMem_Ack) state_q <= StFetch;
        end
        default: ;
      endcase
    end else if (Change_PC_en) begin
      pc_q  <= PC_New & AlignMask;
      req_q <= 1'b1;
      if (req_q && !IMem_Ack) begin
        state_q <= StDrop;
        // A second redirect while dropping keeps the original stale address.
        if (state_q == StFetch) stale_q <= pc_q;
      end else begin
        state_q <= StFetch;
      end
    end else begin
      case (state_q)
        StFetch: begin
          if (IMem_Ack) pc_q <= pc_q + PcStep;
        end
        StHold: begin
          pc_q    <= pc_q + PcStep;
          state_q <= StFetch;
          req_q   <= 1'b1;
        end
        StDrop: begin
          if (IMem_Ack) state_q <= StFetch;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    word_avail = (state_q == StHold) || ((state_q == StFetch) && IMem_Ack);
    id_flush   = Change_PC_en || !word_avail;
    id_instr   = (state_q == StHold) ? buf_q : IMem_Rdata;
  end

  assign IMem_Req  = req_q;
  assign IMem_Addr = (state_q == StDrop) ? stale_q : pc_q;

  if_id_reg u_if_id_reg (
    .clk_i   (clk),
    .rst_i   (rst),
    .hold_i  (Stall_IF_ID),
    .flush_i (id_flush),
    .instr_i (id_instr),
    .pc_i    (pc_q),
    .instr_o (Instruction),
    .pc_o    (ID_PC),
    .valid_o (ID_Valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Change_PC_en = 1'b0;
  logic [31:0] PC_New = 32'h0;
  logic        Stall_IF_ID = 1'b0;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ack;
  logic [31:0] IMem_Rdata;
  logic [31:0] Instruction;
  logic [31:0] ID_PC;
  logic        ID_Valid;

  int total = 0;
  int bad   = 0;

  // Memory model: ack after mem_wait cycles of an outstanding request.
  int          mem_wait = 0;
  int          wait_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .Change_PC_en (Change_PC_en),
    .PC_New       (PC_New),
    .Stall_IF_ID  (Stall_IF_ID),
    .IMem_Req     (IMem_Req),
    .IMem_Addr    (IMem_Addr),
    .IMem_Ack     (IMem_Ack),
    .IMem_Rdata   (IMem_Rdata),
    .Instruction  (Instruction),
    .ID_PC        (ID_PC),
    .ID_Valid     (ID_Valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  always_comb begin
    IMem_Ack   = IMem_Req && (wait_cnt >= mem_wait);
    IMem_Rdata = IMem_Ack ? mem_word(IMem_Addr) : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (rst || !IMem_Req || IMem_Ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    stall_prev <= Stall_IF_ID;
  end

  // Monitor: every fresh valid IF/ID presentation must match the scoreboard head.
  always @(negedge clk) begin
    logic [63:0] exp;
    if (!rst && ID_Valid && !stall_prev) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: id_pc=%h instr=%h, none expected", ID_PC, Instruction);
      end else begin
        exp = sb.pop_front();
        if ({ID_PC, Instruction} !== exp) begin
          bad++;
          $display("FAIL ifid_output: got pc=%h instr=%h expected pc=%h instr=%h",
                   ID_PC, Instruction, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  task automatic push(input logic [31:0] pc);
    sb.push_back({pc, mem_word(pc)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic redirect(input logic [31:0] tgt);
    Change_PC_en = 1'b1;
    PC_New       = tgt;
    step();
    Change_PC_en = 1'b0;
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_id_pc", ID_PC, 32'h0);
    chk("rst_valid", {31'h0, ID_Valid}, 32'h0);
    chk("rst_addr", IMem_Addr, 32'h0);
    chk("rst_req", {31'h0, IMem_Req}, 32'h1);
    rst = 1'b0;

    // Zero-wait streaming 0,4,8,C
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    step();
    chk("first_valid", {31'h0, ID_Valid}, 32'h1);
    repeat (3) step();
    chk("stream_addr", IMem_Addr, 32'h10);

    // Redirect at PC=0x10 to 0x40: one bubble then 0x40
    redirect(32'h40);
    chk("redir_bubble", {31'h0, ID_Valid}, 32'h0);
    chk("redir_addr", IMem_Addr, 32'h40);
    push(32'h40);
    step();

    // Stall while fetching 0x8 with 0x4 in IF/ID
    redirect(32'h4);
    push(32'h4);
    step();
    Stall_IF_ID = 1'b1;
    step();
    chk("stall1_id_pc", ID_PC, 32'h4);
    chk("stall1_req", {31'h0, IMem_Req}, 32'h0);
    step();
    chk("stall2_id_pc", ID_PC, 32'h4);
    chk("stall2_req", {31'h0, IMem_Req}, 32'h0);
    Stall_IF_ID = 1'b0;
    push(32'h8);
    step();
    chk("release_id_pc", ID_PC, 32'h8);
    chk("release_addr", IMem_Addr, 32'hC);

    // Redirect to 0x80 during a 3-cycle wait on 0x20
    redirect(32'h20);
    mem_wait = 3;
    step();
    step();
    redirect(32'h80);
    chk("drop_addr", IMem_Addr, 32'h20);
    chk("drop_req", {31'h0, IMem_Req}, 32'h1);
    chk("drop_bubble", {31'h0, ID_Valid}, 32'h0);
    step();
    chk("drop_next_addr", IMem_Addr, 32'h80);
    chk("drop_bubble2", {31'h0, ID_Valid}, 32'h0);
    mem_wait = 0;
    push(32'h80);
    step();

    // Stall together with redirect: redirect ignored; later unaligned target
    Stall_IF_ID  = 1'b1;
    Change_PC_en = 1'b1;
    PC_New       = 32'h3;
    step();
    chk("stallredir_id_pc", ID_PC, 32'h80);
    chk("stallredir_addr", IMem_Addr, 32'h84);
    Stall_IF_ID = 1'b0;
    redirect(32'h3);
    chk("align_addr", IMem_Addr, 32'h0);
    chk("align_bubble", {31'h0, ID_Valid}, 32'h0);
    push(32'h0);
    step();

    // PC wrap-around
    redirect(32'hFFFF_FFFC);
    push(32'hFFFF_FFFC);
    step();
    chk("wrap_addr", IMem_Addr, 32'h0);

    // Reset mid-wait
    redirect(32'h100);
    mem_wait = 3;
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrst_addr", IMem_Addr, 32'h0);
    chk("midrst_req", {31'h0, IMem_Req}, 32'h1);
    chk("midrst_valid", {31'h0, ID_Valid}, 32'h0);
    chk("midrst_instr", Instruction, 32'h0);
    chk("midrst_id_pc", ID_PC, 32'h0);
    rst = 1'b0;
    mem_wait = 0;
    push(32'h0);
    step();
    chk("postrst_addr", IMem_Addr, 32'h4);
    Stall_IF_ID = 1'b1;
    step();
    step();

    chk("sb_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
